multi_filter_stim: RTL and testbench

Parametrised successor to the single-channel fixed-input filter test top. It provides N_CH independent first-order low-pass filter emulators in signed fixed point. Each channel has a debounced button-driven step stimulus with sign selectable by switch, a shared programmable update tick, and threshold LEDs. It sits as the FPGA-side stimulus/response block between board I/O (buttons, switches, LEDs) and the emulated analog filter outputs.

---
 rtl/multi_filter_stim.sv | 139 +++++++++++++
 tb/tb_multi_filter_stim.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_filter_stim.sv
// N_CH first-order low-pass filter emulators with debounced button step stimulus,
// a shared programmable update tick and per-channel threshold LEDs.

module multi_filter_stim_ch #(
  parameter int W       = 18,
  parameter int FRAC    = 14,
  parameter int K_SHIFT = 4,
  parameter int DB_CYC  = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic                i_mode,
  input  logic                i_btn,
  output logic signed [W-1:0] o_y,
  output logic                o_led
);
  localparam int CW = $clog2(DB_CYC + 1);
  localparam logic signed [W-1:0] ONE   = W'(1) << FRAC;
  localparam logic signed [W-1:0] HALF  = ONE >>> 1;
  localparam logic signed [W-1:0] MAXV  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV  = {1'b1, {(W-1){1'b0}}};

  logic [1:0]          r_sync;
  logic                r_db;
  logic [CW-1:0]       r_cnt;
  logic signed [W-1:0] r_y;
  logic                r_led;

  logic signed [W-1:0] w_x;
  logic signed [W:0]   w_d, w_s, w_sum;
  logic signed [W-1:0] w_ynext;
  logic                w_led;

  always_comb begin
    w_x = '0;
    if (r_db) w_x = i_mode ? -ONE : ONE;
  end

  // Floor shift without rounding: positive steps stall just below ONE by design.
  assign w_d   = {w_x[W-1], w_x} - {r_y[W-1], r_y};
  assign w_s   = w_d >>> K_SHIFT;
  assign w_sum = {r_y[W-1], r_y} + w_s;

  always_comb begin
    w_ynext = w_sum[W-1:0];
    if (w_sum[W] != w_sum[W-1]) w_ynext = w_sum[W] ? MINV : MAXV;
  end

  assign w_led = w_ynext[W-1] ? (w_ynext <= -HALF) : (w_ynext >= HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
      r_y    <= '0;
      r_led  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (r_sync[1] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYC - 1)) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_tick) begin
        r_y   <= w_ynext;
        r_led <= w_led;
      end
    end
  end

  assign o_y   = r_y;
  assign o_led = r_led;
endmodule

module multi_filter_stim #(
  parameter int N_CH     = 2,
  parameter int W        = 18,
  parameter int FRAC     = 14,
  parameter int K_SHIFT  = 4,
  parameter int TICK_DIV = 100,
  parameter int DB_CYC   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sw_mode,
  input  logic [N_CH-1:0]   btn,
  output logic [N_CH*W-1:0] v_out,
  output logic [N_CH-1:0]   led,
  output logic              tick_out
);
  localparam int TCW = $clog2(TICK_DIV);

  if (FRAC > W - 2 || K_SHIFT < 1 || K_SHIFT > W - 2 || TICK_DIV < 2 || DB_CYC < 1) begin : g_bad_param
    $error("multi_filter_stim: illegal parameter combination");
  end

  logic [1:0]                r_mode_sync;
  logic [TCW-1:0]            r_tcnt;
  logic                      r_tick_out;
  logic                      w_tick;
  logic [N_CH-1:0][W-1:0]    w_y;

  assign w_tick = en && (r_tcnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_sync <= '0;
      r_tcnt      <= '0;
      r_tick_out  <= 1'b0;
    end else begin
      r_mode_sync <= {r_mode_sync[0], sw_mode};
      r_tick_out  <= w_tick;
      if (en) r_tcnt <= w_tick ? '0 : r_tcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    multi_filter_stim_ch #(
      .W(W), .FRAC(FRAC), .K_SHIFT(K_SHIFT), .DB_CYC(DB_CYC)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_tick (w_tick),
      .i_mode (r_mode_sync[1]),
      .i_btn  (btn[g]),
      .o_y    (w_y[g]),
      .o_led  (led[g])
    );
  end

  assign v_out    = w_y;
  assign tick_out = r_tick_out;
endmodule

// File: tb/tb_multi_filter_stim.sv
// Bench for multi_filter_stim: directed scenarios plus random stimulus checked
// against an integer-arithmetic reference model.

module tb_multi_filter_stim;
  localparam int NCH = 2, W = 18, FRAC = 14, K = 4, TD = 4, DB = 3;
  localparam int ONE = 16384, HALF = 8192;

  logic clk = 1'b0;
  logic rst_n, en, sw_mode;
  logic [NCH-1:0]   btn;
  logic [NCH*W-1:0] v_out;
  logic [NCH-1:0]   led;
  logic             tick_out;

  int checks = 0, failures = 0;

  multi_filter_stim #(
    .N_CH(NCH), .W(W), .FRAC(FRAC), .K_SHIFT(K), .TICK_DIV(TD), .DB_CYC(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sw_mode(sw_mode), .btn(btn),
    .v_out(v_out), .led(led), .tick_out(tick_out)
  );

  always #5 clk = ~clk;

  // Reference model: inputs seen through two cycles of delay, a change accepted
  // after DB consecutive differing cycles, y += floor((x - y) / 2^K) per tick.
  int             m_y [NCH];
  int             m_run [NCH];
  int             m_ph;
  logic [NCH-1:0] m_led, m_s1, m_s2, m_db;
  logic           m_md1, m_md2, m_tick;

  function automatic int fdiv(int d, int den);
    return (d >= 0) ? d / den : -((-d + den - 1) / den);
  endfunction

  function automatic int nexty(int y, int x);
    int r;
    r = y + fdiv(x - y, 1 << K);
    if (r > (1 << (W-1)) - 1) r = (1 << (W-1)) - 1;
    if (r < -(1 << (W-1)))    r = -(1 << (W-1));
    return r;
  endfunction

  function automatic int xval(logic db, logic md);
    return db ? (md ? -ONE : ONE) : 0;
  endfunction

  function automatic int iabs(int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic logic [NCH*W-1:0] mvpack();
    logic [NCH*W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = m_y[i][W-1:0];
    return r;
  endfunction

  function automatic int yv(int i);
    logic signed [W-1:0] s;
    s = v_out[i*W +: W];
    return int'(s);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin m_y[i] <= 0; m_run[i] <= 0; end
      m_ph <= 0; m_led <= '0; m_s1 <= '0; m_s2 <= '0; m_db <= '0;
      m_md1 <= 1'b0; m_md2 <= 1'b0; m_tick <= 1'b0;
    end else begin
      m_tick <= en && (m_ph == TD - 1);
      if (en) m_ph <= (m_ph + 1) % TD;
      for (int i = 0; i < NCH; i++) begin
        if (en && m_ph == TD - 1) begin
          m_y[i]   <= nexty(m_y[i], xval(m_db[i], m_md2));
          m_led[i] <= iabs(nexty(m_y[i], xval(m_db[i], m_md2))) >= HALF;
        end
        if (m_s2[i] == m_db[i]) m_run[i] <= 0;
        else if (m_run[i] + 1 >= DB) begin m_db[i] <= m_s2[i]; m_run[i] <= 0; end
        else m_run[i] <= m_run[i] + 1;
      end
      m_s1 <= btn; m_s2 <= m_s1; m_md1 <= sw_mode; m_md2 <= m_md1;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; sw_mode = 1'b0; btn = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      en = 1'($urandom); sw_mode = 1'($urandom); btn = NCH'($urandom);
      #1;
      checks++;
      if ({v_out, led, tick_out} !== '0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got v=%h led=%b tick=%b need all 0", c, v_out, led, tick_out);
      end
    end
    @(negedge clk);
    en = 1'b0; sw_mode = 1'b0; btn = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tick();
    int pulses = 0;
    en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      pulses += int'(tick_out);
      checks++;
      if ({v_out, led, tick_out} !== {mvpack(), m_led, m_tick}) begin
        failures++;
        $display("FAIL tick_scb got v=%h led=%b tick=%b exp v=%h led=%b tick=%b", v_out, led, tick_out, mvpack(), m_led, m_tick);
      end
    end
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL tick_count got %0d need 4", pulses);
    end
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (tick_out !== 1'b0) begin
        failures++;
        $display("FAIL tick_paused cyc=%0d got %b need 0", c, tick_out);
      end
    end
    en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (tick_out !== (c == 2)) begin
        failures++;
        $display("FAIL tick_resume cyc=%0d got %b need %b", c, tick_out, c == 2);
      end
    end
  endtask

  task automatic test_debounce();
    int exp_seq [3] = '{1024, 1984, 2884};
    int k = 0, budget;
    sw_mode = 1'b0;
    btn[0] = 1'b1;
    repeat (2) @(negedge clk);
    btn[0] = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checks++;
      if (v_out !== '0) begin
        failures++;
        $display("FAIL glitch_ignored cyc=%0d got v=%h need 0", c, v_out);
      end
    end
    btn[0] = 1'b1;
    budget = 400;
    while (budget > 0 && !(led[0] === 1'b1)) begin
      @(negedge clk);
      budget--;
      checks++;
      if ({v_out, led, tick_out} !== {mvpack(), m_led, m_tick}) begin
        failures++;
        $display("FAIL deb_scb got v=%h led=%b exp v=%h led=%b", v_out, led, mvpack(), m_led);
      end
      if (tick_out === 1'b1) begin
        if (k < 3 && yv(0) != 0) begin
          checks++;
          if (yv(0) != exp_seq[k]) begin
            failures++;
            $display("FAIL step_seq idx=%0d got %0d need %0d", k, yv(0), exp_seq[k]);
          end
          k++;
        end
        checks++;
        if (led[0] !== (yv(0) >= HALF) || yv(1) != 0 || led[1] !== 1'b0) begin
          failures++;
          $display("FAIL led0_thresh y0=%0d led=%b y1=%0d", yv(0), led, yv(1));
        end
      end
    end
    checks++;
    if (budget == 0 || k != 3) begin
      failures++;
      $display("FAIL deb_timeout steps_seen=%0d need 3 led0=%b", k, led[0]);
    end
  endtask

  task automatic test_negative();
    int exp_seq [2] = '{-1024, -1984};
    int k = 0;
    sw_mode = 1'b1;
    btn = 2'b10;
    for (int c = 0; c < 1240; c++) begin
      @(negedge clk);
      checks++;
      if ({v_out, led, tick_out} !== {mvpack(), m_led, m_tick}) begin
        failures++;
        $display("FAIL neg_scb got v=%h led=%b exp v=%h led=%b", v_out, led, mvpack(), m_led);
      end
      if (tick_out === 1'b1 && k < 2 && yv(1) != 0) begin
        checks++;
        if (yv(1) != exp_seq[k]) begin
          failures++;
          $display("FAIL neg_seq idx=%0d got %0d need %0d", k, yv(1), exp_seq[k]);
        end
        k++;
      end
    end
    checks++;
    if (yv(1) != -ONE || led[1] !== 1'b1 || k != 2) begin
      failures++;
      $display("FAIL neg_final got y1=%0d led1=%b steps=%0d need -16384 1 2", yv(1), led[1], k);
    end
  endtask

  task automatic test_positive();
    sw_mode = 1'b0;
    btn = 2'b01;
    for (int c = 0; c < 1220; c++) begin
      @(negedge clk);
      checks++;
      if ({v_out, led, tick_out} !== {mvpack(), m_led, m_tick}) begin
        failures++;
        $display("FAIL pos_scb got v=%h led=%b exp v=%h led=%b", v_out, led, mvpack(), m_led);
      end
    end
    checks++;
    if (yv(0) < ONE - 15 || yv(0) > ONE || led[0] !== 1'b1) begin
      failures++;
      $display("FAIL pos_final got y0=%0d led0=%b need [16369,16384] 1", yv(0), led[0]);
    end
    btn = 2'b00;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if ({v_out, led, tick_out} !== {mvpack(), m_led, m_tick}) begin
        failures++;
        $display("FAIL decay_scb got v=%h led=%b exp v=%h led=%b", v_out, led, mvpack(), m_led);
      end
      if (tick_out === 1'b1) begin
        checks++;
        if (led[0] !== (iabs(yv(0)) >= HALF)) begin
          failures++;
          $display("FAIL decay_led y0=%0d got %b", yv(0), led[0]);
        end
      end
    end
    checks++;
    if (led[0] !== 1'b0 || yv(0) <= 0 || yv(0) >= HALF) begin
      failures++;
      $display("FAIL decay_final got y0=%0d led0=%b need (0,8192) 0", yv(0), led[0]);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (v_out !== '0 || led !== '0 || tick_out !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got v=%h led=%b tick=%b need 0", v_out, led, tick_out);
    end
    #1 rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tick_out !== (c == 4) || v_out !== '0) begin
        failures++;
        $display("FAIL post_reset_tick edge=%0d got tick=%b v=%h need tick=%b v=0", c, tick_out, v_out, c == 4);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      checks++;
      if ({v_out, led, tick_out} !== {mvpack(), m_led, m_tick}) begin
        failures++;
        $display("FAIL rand_scb cyc=%0d got v=%h led=%b tick=%b exp v=%h led=%b tick=%b", c, v_out, led, tick_out, mvpack(), m_led, m_tick);
      end
      if ($urandom_range(7) == 0)  btn[$urandom_range(NCH-1)] ^= 1'b1;
      if ($urandom_range(59) == 0) en = ~en;
      if ($urandom_range(149) == 0) sw_mode = ~sw_mode;
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_debounce();
    test_negative();
    test_positive();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
